// File: rtl/seg_scan_ctrl.sv
// ============================================================================
//  Module   : seg_scan_ctrl
//  Brief    : Eight-digit multiplexed 7-segment scan controller with a
//             shadow-buffered, tear-free update port committed at frame ends.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl #(
  parameter int DWELL = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_en_mask,
  input  logic [7:0]  wr_dp,
  output logic [7:0]  digit_sel_o,
  output logic [7:0]  seg_o,
  output logic        frame_o
);

  localparam logic [15:0] c_cnt_last = 16'(DWELL - 1);

  logic [2:0]  r_idx;
  logic [15:0] r_cnt;
  logic [31:0] r_act_data;
  logic [7:0]  r_act_mask;
  logic [7:0]  r_act_dp;
  logic [31:0] r_sh_data;
  logic [7:0]  r_sh_mask;
  logic [7:0]  r_sh_dp;
  logic        r_pend;

  logic        w_slot_end;
  logic        w_boundary;
  logic        w_xfer;
  logic [3:0]  w_nibble;
  logic [6:0]  w_dec;

  assign w_slot_end = (r_cnt == c_cnt_last);
  assign w_boundary = w_slot_end && (r_idx == 3'd7);
  assign wr_ready   = !r_pend;
  assign w_xfer     = wr_valid && !r_pend;
  assign w_nibble   = r_act_data[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_dec = 7'h00;
    case (w_nibble)
      4'h0: w_dec = 7'h3F;
      4'h1: w_dec = 7'h06;
      4'h2: w_dec = 7'h5B;
      4'h3: w_dec = 7'h4F;
      4'h4: w_dec = 7'h66;
      4'h5: w_dec = 7'h6D;
      4'h6: w_dec = 7'h7D;
      4'h7: w_dec = 7'h07;
      4'h8: w_dec = 7'h7F;
      4'h9: w_dec = 7'h6F;
      4'hA: w_dec = 7'h77;
      4'hB: w_dec = 7'h7C;
      4'hC: w_dec = 7'h39;
      4'hD: w_dec = 7'h5E;
      4'hE: w_dec = 7'h79;
      4'hF: w_dec = 7'h71;
      default: w_dec = 7'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= 3'd0;
      r_cnt <= 16'd0;
    end else if (w_slot_end) begin
      r_cnt <= 16'd0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Commit only on the frame boundary; ready is low while pending, so a
  // boundary commit and a new capture can never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act_data <= 32'd0;
      r_act_mask <= 8'd0;
      r_act_dp   <= 8'd0;
      r_sh_data  <= 32'd0;
      r_sh_mask  <= 8'd0;
      r_sh_dp    <= 8'd0;
      r_pend     <= 1'b0;
    end else if (w_boundary && r_pend) begin
      r_act_data <= r_sh_data;
      r_act_mask <= r_sh_mask;
      r_act_dp   <= r_sh_dp;
      r_pend     <= 1'b0;
    end else if (w_xfer) begin
      r_sh_data  <= wr_data;
      r_sh_mask  <= wr_en_mask;
      r_sh_dp    <= wr_dp;
      r_pend     <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_sel_o <= 8'd0;
      seg_o       <= 8'd0;
      frame_o     <= 1'b0;
    end else begin
      frame_o <= w_boundary;
      if (r_act_mask[r_idx]) begin
        digit_sel_o <= 8'd1 << r_idx;
        seg_o       <= {r_act_dp[r_idx], w_dec};
      end else begin
        digit_sel_o <= 8'd0;
        seg_o       <= 8'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Brief    : Self-checking bench for seg_scan_ctrl (DWELL=3 and DWELL=1).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

  localparam int c_n = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid   [c_n];
  logic        wr_ready   [c_n];
  logic [31:0] wr_data    [c_n];
  logic [7:0]  wr_en_mask [c_n];
  logic [7:0]  wr_dp      [c_n];
  logic [7:0]  digit_sel_o[c_n];
  logic [7:0]  seg_o      [c_n];
  logic        frame_o    [c_n];

  int npass = 0;
  int ntotal = 0;

  // Reference model: per-instance display contents, pending update and
  // cycle count since reset release.
  int          cyc     [c_n];
  logic [31:0] m_data  [c_n];
  logic [7:0]  m_mask  [c_n];
  logic [7:0]  m_dp    [c_n];
  logic [31:0] s_data  [c_n];
  logic [7:0]  s_mask  [c_n];
  logic [7:0]  s_dp    [c_n];
  bit          m_pend  [c_n];
  bit          last_xfer[c_n];

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DWELL(3)) u_dut0 (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_data(wr_data[0]),
    .wr_en_mask(wr_en_mask[0]), .wr_dp(wr_dp[0]),
    .digit_sel_o(digit_sel_o[0]), .seg_o(seg_o[0]), .frame_o(frame_o[0])
  );

  seg_scan_ctrl #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_data(wr_data[1]),
    .wr_en_mask(wr_en_mask[1]), .wr_dp(wr_dp[1]),
    .digit_sel_o(digit_sel_o[1]), .seg_o(seg_o[1]), .frame_o(frame_o[1])
  );

  function automatic int dw(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[n];
  endfunction

  task automatic chk(input string tag, input int inst, input logic [7:0] obs,
                     input logic [7:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s[%0d] observed=%h expected=%h (t=%0t)", tag, inst, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < c_n; i++) begin
      cyc[i] = 0; m_data[i] = '0; m_mask[i] = '0; m_dp[i] = '0;
      s_data[i] = '0; s_mask[i] = '0; s_dp[i] = '0;
      m_pend[i] = 0; last_xfer[i] = 0;
    end
  endtask

  // One clock: predict outputs from the displayed frame contents, then
  // compare after the edge.
  task automatic tick();
    logic [7:0] es [c_n];
    logic [7:0] eg [c_n];
    logic       ef [c_n];
    for (int i = 0; i < c_n; i++) begin
      int d;
      int slot;
      bit bnd;
      d    = dw(i);
      slot = (cyc[i] / d) % 8;
      bnd  = (cyc[i] % (8 * d)) == (8 * d - 1);
      es[i] = m_mask[i][slot] ? 8'(1 << slot) : 8'h00;
      eg[i] = m_mask[i][slot] ? {m_dp[i][slot], seg7(m_data[i][4*slot +: 4])} : 8'h00;
      ef[i] = bnd;
      last_xfer[i] = wr_valid[i] && !m_pend[i];
      if (bnd && m_pend[i]) begin
        m_data[i] = s_data[i]; m_mask[i] = s_mask[i]; m_dp[i] = s_dp[i];
        m_pend[i] = 0;
      end else if (last_xfer[i]) begin
        s_data[i] = wr_data[i]; s_mask[i] = wr_en_mask[i]; s_dp[i] = wr_dp[i];
        m_pend[i] = 1;
      end
      cyc[i]++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < c_n; i++) begin
      chk("digit_sel", i, digit_sel_o[i], es[i]);
      chk("seg", i, seg_o[i], eg[i]);
      chk("frame", i, {7'd0, frame_o[i]}, {7'd0, ef[i]});
      chk("wr_ready", i, {7'd0, wr_ready[i]}, {7'd0, !m_pend[i]});
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Tick until every raised wr_valid has been accepted, dropping each one.
  task automatic run_until_accepted();
    int budget;
    budget = 400;
    while ((wr_valid[0] || wr_valid[1]) && budget > 0) begin
      tick();
      for (int i = 0; i < c_n; i++) if (last_xfer[i]) wr_valid[i] = 1'b0;
      budget--;
    end
    if (budget == 0) chk("accept_timeout", 0, 8'd0, 8'd1);
  endtask

  task automatic run_random(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      for (int i = 0; i < c_n; i++) begin
        if (last_xfer[i]) wr_valid[i] = 1'b0;
        if (!wr_valid[i] && $urandom_range(0, 5) == 0) begin
          wr_valid[i]   = 1'b1;
          wr_data[i]    = $urandom;
          wr_en_mask[i] = 8'($urandom);
          wr_dp[i]      = 8'($urandom);
        end
      end
    end
  endtask

  task automatic load(input int i, input logic [31:0] d, input logic [7:0] m,
                      input logic [7:0] p);
    wr_valid[i] = 1'b1; wr_data[i] = d; wr_en_mask[i] = m; wr_dp[i] = p;
  endtask

  initial begin
    for (int i = 0; i < c_n; i++) begin
      wr_valid[i] = 1'b0; wr_data[i] = '0; wr_en_mask[i] = '0; wr_dp[i] = '0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < c_n; i++) begin
      chk("rst_sel", i, digit_sel_o[i], 8'h00);
      chk("rst_seg", i, seg_o[i], 8'h00);
      chk("rst_frame", i, {7'd0, frame_o[i]}, 8'h00);
      chk("rst_ready", i, {7'd0, wr_ready[i]}, 8'h01);
    end
    rst = 1'b0;

    // Two lit digits, then tear-free display over several frames.
    load(0, 32'h0000_0012, 8'h03, 8'h00);
    load(1, 32'h0000_0012, 8'h03, 8'h00);
    run_until_accepted();
    run(60);

    // Second request held while the first is pending.
    load(0, 32'h1234_5678, 8'hF0, 8'h0F);
    load(1, 32'h1234_5678, 8'hF0, 8'h0F);
    run_until_accepted();
    load(0, 32'h9ABC_DEF0, 8'hFF, 8'hAA);
    load(1, 32'h9ABC_DEF0, 8'hFF, 8'hAA);
    run_until_accepted();
    run(50);

    // Transfer exactly in a boundary cycle of the DWELL=3 instance.
    while ((cyc[0] % 24) != 23) tick();
    load(0, 32'hCAFE_0042, 8'h5A, 8'h11);
    tick();
    wr_valid[0] = 1'b0;
    run(55);

    // All eight digits, dp on digit 7, on the DWELL=1 instance.
    load(1, 32'hFEDC_BA98, 8'hFF, 8'h80);
    run_until_accepted();
    run(30);

    run_random(400);

    // Mid-frame reset with updates pending.
    for (int i = 0; i < c_n; i++) wr_valid[i] = 1'b0;
    run(30);
    load(0, 32'h7777_7777, 8'hFF, 8'hFF);
    load(1, 32'h7777_7777, 8'hFF, 8'hFF);
    tick();
    for (int i = 0; i < c_n; i++) wr_valid[i] = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < c_n; i++) begin
      chk("midrst_sel", i, digit_sel_o[i], 8'h00);
      chk("midrst_seg", i, seg_o[i], 8'h00);
      chk("midrst_ready", i, {7'd0, wr_ready[i]}, 8'h01);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < c_n; i++) begin
      chk("midrst_frame", i, {7'd0, frame_o[i]}, 8'h00);
      chk("midrst_sel2", i, digit_sel_o[i], 8'h00);
    end
    rst = 1'b0;
    model_reset();
    run(40);
    run_random(300);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 1000: clk cycles each digit is driven per scan slot; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; it is asynchronous and active-high.
REQ-004 SHALL have port wr_valid, input, 1, the requester offers a display update.
REQ-005 SHALL have port wr_ready, output, 1, the block can accept an update.
REQ-006 SHALL have port wr_data, input, 32, eight hex nibbles; nibble k is [4k+3:4k] and drives digit k.
REQ-007 SHALL have port wr_en_mask, input, 8, where bit k=1 enables digit k.
REQ-008 SHALL have port wr_dp, input, 8, where bit k=1 lights the decimal point of digit k.
REQ-009 SHALL have port digit_sel_o, output, 8, a one-hot active-high digit strobe (all-zero when the slot is blanked).
REQ-010 SHALL have port seg_o, output, 8, the segment pattern: bit0..6 = a..g, bit7 = dp, active-high.
REQ-011 SHALL have port frame_o, output, 1, a one-cycle pulse marking the start of a new frame.

Function
REQ-012 SHALL keep scan index idx (3 bits) and dwell counter cnt (16 bits); cnt==DWELL-1 SHALL set cnt to 0 and idx to idx+1, wrapping 7->0, otherwise cnt increments.
REQ-013 SHALL define the boundary cycle as the cycle with idx==7 and cnt==DWELL-1; one frame = 8*DWELL cycles.
REQ-014 SHALL hold active registers (act_data, act_mask, act_dp) and shadow registers (sh_data, sh_mask, sh_dp) plus a pend flag.
REQ-015 SHALL drive wr_ready = !pend combinationally; a transfer occurs when wr_valid && wr_ready.
REQ-016 On a transfer, the shadow registers SHALL capture wr_data/wr_en_mask/wr_dp and pend SHALL set.
REQ-017 On a boundary cycle with pend==1, active registers SHALL load from the shadow and pend SHALL clear; the active registers SHALL never change mid-frame (no tearing).
REQ-018 SHALL treat a transfer during a boundary cycle with pend==0 as pending and commit it at the next boundary, not the current one.
REQ-019 SHALL ignore wr_* while pend==1; the requester holds wr_valid until wr_ready.
REQ-020 SHALL register outputs every cycle: digit_sel_o <= act_mask[idx] ? onehot(idx) : 0, and seg_o <= act_mask[idx] ? {act_dp[idx], dec(nibble idx)} : 0.
REQ-021 dec SHALL map nibbles 0..F to 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex, bits 6..0).
REQ-022 frame_o SHALL be registered and high for exactly the one cycle following each boundary cycle, whether or not a commit occurred.
REQ-023 For DWELL==1, idx SHALL advance every cycle, every 8th cycle SHALL be a boundary, and there SHALL be no stall.
REQ-024 Update latency from transfer to first changed output SHALL be at most 8*DWELL+2 cycles.

Reset
REQ-025 While rst is high: idx=0, cnt=0, act_*=0, sh_*=0, pend=0, digit_sel_o=0, seg_o=0, frame_o=0; wr_ready SHALL therefore read 1.
REQ-026 Assertion of rst mid-frame SHALL discard any pending update, and scanning SHALL restart at digit 0 with cnt=0 on the first edge after release.

Verification
REQ-027 DWELL=2; reset; transfer data 0x0000_0012, mask 0x03, dp 0x00 -> after the first boundary, the digit 0 slot gives digit_sel_o=0x01, seg_o=0x5B; the digit 1 slot gives 0x02, 0x06; slots 2..7 give 0x00, 0x00.
REQ-028 DWELL=2; transfer accepted, then a second wr_valid before the boundary -> wr_ready=0 until the boundary cycle; the first value commits; the second is accepted the cycle after the commit.
REQ-029 DWELL=4; transfer in exactly the boundary cycle with pend=0 -> the old value is displayed for the whole next frame; the new value commits at the following boundary.
REQ-030 DWELL=1; data 0xFEDC_BA98, mask 0xFF, dp 0x80 -> seg_o sequence 7F,6F,77,7C,39,5E,79,F1 repeating; frame_o pulses every 8 cycles.
REQ-031 DWELL=3; rst pulsed mid-frame with pend=1 -> all outputs 0 while rst is high, pend is cleared, and wr_ready=1; after release, blank frames until a new transfer.
REQ-032 DWELL=65535 -> cnt reaches 0xFFFE then wraps to 0 with an idx increment, with no overflow.
